// File: rtl/cp0_exception_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exception_unit_if
// Purpose  : Core <-> CP0 instruction-side bus (MTC0/MFC0/ERET/exception flags).
// Revision : 1.0 - initial release
// ============================================================================
interface cp0_exception_unit_if;
  logic [31:0] PresentPC;
  logic        IsCOP0;
  logic        IsMtc0;
  logic        IsEret;
  logic        IsSyscall;
  logic        IsUndef;
  logic        Overflow;
  logic [4:0]  Rd;
  logic [31:0] WriteData;
  logic        HasExp;
  logic [31:0] EPC;
  logic [31:0] ReadData;
  logic [4:0]  ExcCode;

  modport master (
    output PresentPC, IsCOP0, IsMtc0, IsEret, IsSyscall, IsUndef, Overflow, Rd, WriteData,
    input  HasExp, EPC, ReadData, ExcCode
  );

  modport slave (
    input  PresentPC, IsCOP0, IsMtc0, IsEret, IsSyscall, IsUndef, Overflow, Rd, WriteData,
    output HasExp, EPC, ReadData, ExcCode
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exception_unit
// Purpose  : CP0 Status/Cause/EPC, interrupt sync, exception priority and ERET.
//            Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exception_unit #(
  parameter int SYNC_STAGES = 2,
  parameter int HW_INT_NUM  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HW_INT_NUM-1:0] HwInt,
  cp0_exception_unit_if.slave   bus
);

  localparam logic [4:0] c_exc_int  = 5'd0;
  localparam logic [4:0] c_exc_ri   = 5'd10;
  localparam logic [4:0] c_exc_ov   = 5'd12;
  localparam logic [4:0] c_exc_sys  = 5'd8;

  logic [HW_INT_NUM-1:0] sync_q [SYNC_STAGES];
  logic [HW_INT_NUM-1:0] sync_d [SYNC_STAGES];

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [1:0]  sw_ip_q, sw_ip_d;
  logic [29:0] epc_q, epc_d;
  logic [4:0]  exc_code_q, exc_code_d;

  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic        timer_pending;
  logic        int_req;
  logic        sync_exc;
  logic        has_exp;
  logic [4:0]  win_code;
  logic        mtc0_en;
  logic        eret_en;
  logic [31:0] read_data;
  logic        unused_pc_bits;

  always_comb begin
    sync_d[0] = HwInt;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Lines beyond HW_INT_NUM read as zero in Cause.IP.
  always_comb begin
    hw_ip = '0;
    for (int i = 0; i < HW_INT_NUM; i++) begin
      hw_ip[i] = sync_q[SYNC_STAGES-1][i];
    end
  end

  assign ip       = {hw_ip[5] | timer_pending, hw_ip[4:0], sw_ip_q};
  assign int_req  = ie_q & ~exl_q & |(ip & im_q);
  assign sync_exc = (bus.IsUndef | bus.Overflow | bus.IsSyscall) & ~exl_q;
  assign has_exp  = int_req | sync_exc;
  assign mtc0_en  = bus.IsCOP0 & bus.IsMtc0 & ~has_exp;
  assign eret_en  = bus.IsCOP0 & bus.IsEret & ~has_exp;

  always_comb begin
    if (int_req)          win_code = c_exc_int;
    else if (bus.IsUndef) win_code = c_exc_ri;
    else if (bus.Overflow) win_code = c_exc_ov;
    else                  win_code = c_exc_sys;
  end

  always_comb begin
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    sw_ip_d    = sw_ip_q;
    epc_d      = epc_q;
    exc_code_d = exc_code_q;
    if (has_exp) begin
      epc_d      = bus.PresentPC[31:2];
      exl_d      = 1'b1;
      exc_code_d = win_code;
    end else begin
      if (mtc0_en) begin
        case (bus.Rd)
          5'd12: begin
            ie_d  = bus.WriteData[0];
            exl_d = bus.WriteData[1];
            im_d  = bus.WriteData[15:8];
          end
          5'd13:   sw_ip_d = bus.WriteData[9:8];
          5'd14:   epc_d   = bus.WriteData[31:2];
          default: ;
        endcase
      end
      // ERET is applied last so it wins over a same-cycle EXL write.
      if (eret_en) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      sw_ip_q    <= '0;
      epc_q      <= '0;
      exc_code_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      sw_ip_q    <= sw_ip_d;
      epc_q      <= epc_d;
      exc_code_q <= exc_code_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_pending_q, timer_pending_d;

  always_comb begin
    count_d         = count_q + 32'd1;
    compare_d       = compare_q;
    timer_pending_d = timer_pending_q;
    if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_pending_d = 1'b1;
    end
    if (mtc0_en && (bus.Rd == 5'd9)) begin
      count_d = bus.WriteData;
    end
    if (mtc0_en && (bus.Rd == 5'd11)) begin
      compare_d       = bus.WriteData;
      timer_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q         <= '0;
      compare_q       <= '0;
      timer_pending_q <= 1'b0;
    end else begin
      count_q         <= count_d;
      compare_q       <= compare_d;
      timer_pending_q <= timer_pending_d;
    end
  end

  assign timer_pending = timer_pending_q;
`else
  assign timer_pending = 1'b0;
`endif

  always_comb begin
    read_data = 32'd0;
    case (bus.Rd)
`ifdef CP0_TIMER_EN
      5'd9:    read_data = count_q;
      5'd11:   read_data = compare_q;
`endif
      5'd12:   read_data = {16'd0, im_q, 6'd0, exl_q, ie_q};
      5'd13:   read_data = {16'd0, ip, 1'b0, exc_code_q, 2'b00};
      5'd14:   read_data = {epc_q, 2'b00};
      default: read_data = 32'd0;
    endcase
  end

  assign bus.HasExp   = has_exp;
  assign bus.EPC      = {epc_q, 2'b00};
  assign bus.ReadData = read_data;
  assign bus.ExcCode  = exc_code_q;

  assign unused_pc_bits = ^bus.PresentPC[1:0];

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exception_unit
// Purpose  : Directed self-checking bench for cp0_exception_unit (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exception_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] hw_int;
  int         n_cmp;
  int         n_bad;

  cp0_exception_unit_if bus ();

  cp0_exception_unit #(
    .SYNC_STAGES (2),
    .HW_INT_NUM  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .HwInt (hw_int),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IsCOP0    = 1'b0;
    bus.IsMtc0    = 1'b0;
    bus.IsEret    = 1'b0;
    bus.IsSyscall = 1'b0;
    bus.IsUndef   = 1'b0;
    bus.Overflow  = 1'b0;
    bus.Rd        = 5'd0;
    bus.WriteData = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] d);
    idle();
    bus.IsCOP0 = 1'b1; bus.IsMtc0 = 1'b1; bus.Rd = rd; bus.WriteData = d;
    step();
    idle();
  endtask

  task automatic eret();
    idle();
    bus.IsCOP0 = 1'b1; bus.IsEret = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    hw_int = '0;
    bus.PresentPC = 32'd0;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL reset_hasexp got %b want 0", bus.HasExp); end
    n_cmp++; if (bus.EPC !== 32'd0) begin n_bad++; $display("FAIL reset_epc got %h want 0", bus.EPC); end
    n_cmp++; if (bus.ExcCode !== 5'd0) begin n_bad++; $display("FAIL reset_exccode got %0d want 0", bus.ExcCode); end
    @(negedge clk); rst_n = 1'b1;
    step();
    for (int r = 12; r <= 14; r++) begin
      bus.Rd = 5'(r); #1;
      n_cmp++; if (bus.ReadData !== 32'd0) begin n_bad++; $display("FAIL reset_mfc0_rd%0d got %h want 0", r, bus.ReadData); end
    end
    idle();
  endtask

  task automatic test_syscall();
    bus.PresentPC = 32'h0000_3010; bus.IsSyscall = 1'b1; #1;
    n_cmp++; if (bus.HasExp !== 1'b1) begin n_bad++; $display("FAIL sys_hasexp got %b want 1", bus.HasExp); end
    step();
    n_cmp++; if (bus.EPC !== 32'h0000_3010) begin n_bad++; $display("FAIL sys_epc got %h want 00003010", bus.EPC); end
    n_cmp++; if (bus.ExcCode !== 5'd8) begin n_bad++; $display("FAIL sys_exccode got %0d want 8", bus.ExcCode); end
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL sys_in_exl_hasexp got %b want 0", bus.HasExp); end
    bus.Rd = 5'd12; #1;
    n_cmp++; if (bus.ReadData !== 32'h2) begin n_bad++; $display("FAIL sys_status got %h want 00000002", bus.ReadData); end
    step();
    n_cmp++; if (bus.EPC !== 32'h0000_3010) begin n_bad++; $display("FAIL sys_ignored_epc got %h want 00003010", bus.EPC); end
    eret();
    bus.Rd = 5'd12; #1;
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_bad++; $display("FAIL eret_status got %h want 0", bus.ReadData); end
    n_cmp++; if (bus.EPC !== 32'h0000_3010) begin n_bad++; $display("FAIL eret_epc got %h want 00003010", bus.EPC); end
    idle();
  endtask

  task automatic test_priority();
    bus.PresentPC = 32'h0000_4006;
    bus.IsUndef = 1'b1; bus.Overflow = 1'b1; bus.IsSyscall = 1'b1;
    bus.IsCOP0 = 1'b1; bus.IsMtc0 = 1'b1; bus.Rd = 5'd14; bus.WriteData = 32'h0000_1234;
    #1;
    n_cmp++; if (bus.HasExp !== 1'b1) begin n_bad++; $display("FAIL prio_hasexp got %b want 1", bus.HasExp); end
    step();
    n_cmp++; if (bus.ExcCode !== 5'd10) begin n_bad++; $display("FAIL prio_undef got %0d want 10", bus.ExcCode); end
    n_cmp++; if (bus.EPC !== 32'h0000_4004) begin n_bad++; $display("FAIL prio_epc got %h want 00004004", bus.EPC); end
    eret();
    bus.PresentPC = 32'h0000_4008; bus.Overflow = 1'b1; bus.IsSyscall = 1'b1;
    step(); idle();
    n_cmp++; if (bus.ExcCode !== 5'd12) begin n_bad++; $display("FAIL prio_ovf got %0d want 12", bus.ExcCode); end
    eret();
    mtc0(5'd14, 32'h0000_1237);
    n_cmp++; if (bus.EPC !== 32'h0000_1234) begin n_bad++; $display("FAIL mtc0_epc got %h want 00001234", bus.EPC); end
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    bus.PresentPC = 32'h0000_5000;
    hw_int = 6'h01; #1;
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL irq_pre got %b want 0", bus.HasExp); end
    step();
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL irq_stage1 got %b want 0", bus.HasExp); end
    step();
    n_cmp++; if (bus.HasExp !== 1'b1) begin n_bad++; $display("FAIL irq_stage2 got %b want 1", bus.HasExp); end
    step();
    n_cmp++; if (bus.ExcCode !== 5'd0) begin n_bad++; $display("FAIL irq_exccode got %0d want 0", bus.ExcCode); end
    n_cmp++; if (bus.EPC !== 32'h0000_5000) begin n_bad++; $display("FAIL irq_epc got %h want 00005000", bus.EPC); end
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL irq_masked_exl got %b want 0", bus.HasExp); end
    eret();
    n_cmp++; if (bus.HasExp !== 1'b1) begin n_bad++; $display("FAIL irq_reenter got %b want 1", bus.HasExp); end
    hw_int = 6'h00;
    step(); step(); step();
    eret();
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL irq_clear got %b want 0", bus.HasExp); end
    bus.Rd = 5'd12; #1;
    n_cmp++; if (bus.ReadData !== 32'h0000_0401) begin n_bad++; $display("FAIL irq_status got %h want 00000401", bus.ReadData); end
    idle();
  endtask

  task automatic test_swint();
    mtc0(5'd12, 32'h0000_0101);
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL swi_pre got %b want 0", bus.HasExp); end
    mtc0(5'd13, 32'h0000_0300);
    bus.Rd = 5'd13; #1;
    n_cmp++; if (bus.ReadData !== 32'h0000_0300) begin n_bad++; $display("FAIL swi_cause got %h want 00000300", bus.ReadData); end
    n_cmp++; if (bus.HasExp !== 1'b1) begin n_bad++; $display("FAIL swi_hasexp got %b want 1", bus.HasExp); end
    step();
    mtc0(5'd13, 32'h0);
    eret();
    n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL swi_clear got %b want 0", bus.HasExp); end
  endtask

  task automatic test_masked();
    mtc0(5'd12, 32'h0000_0001);
    hw_int = 6'h3F;
    bus.Rd = 5'd13; #1;
    step();
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_bad++; $display("FAIL mask_ip_early got %h want 0", bus.ReadData); end
    step();
    n_cmp++; if (bus.ReadData !== 32'h0000_FC00) begin n_bad++; $display("FAIL mask_ip got %h want 0000fc00", bus.ReadData); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.HasExp !== 1'b0) begin n_bad++; $display("FAIL mask_hasexp%0d got %b want 0", k, bus.HasExp); end
      step();
    end
    hw_int = 6'h00;
    step(); step();
    idle();
  endtask

  task automatic test_unimpl();
    mtc0(5'd9, 32'hFFFF_FFFF);
    mtc0(5'd11, 32'h0000_0005);
    bus.Rd = 5'd9; #1;
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_bad++; $display("FAIL count_rd got %h want 0", bus.ReadData); end
    bus.Rd = 5'd11; #1;
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_bad++; $display("FAIL compare_rd got %h want 0", bus.ReadData); end
    bus.Rd = 5'd15; #1;
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_bad++; $display("FAIL rd15 got %h want 0", bus.ReadData); end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.PresentPC = 32'h0000_6008; bus.IsSyscall = 1'b1;
    step(); idle();
    bus.Rd = 5'd12; #1;
    n_cmp++; if (bus.ReadData !== 32'h3) begin n_bad++; $display("FAIL mid_status got %h want 00000003", bus.ReadData); end
    #1; rst_n = 1'b0; #1;
    n_cmp++; if (bus.EPC !== 32'h0) begin n_bad++; $display("FAIL mid_rst_epc got %h want 0", bus.EPC); end
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_bad++; $display("FAIL mid_rst_status got %h want 0", bus.ReadData); end
    n_cmp++; if (bus.ExcCode !== 5'd0) begin n_bad++; $display("FAIL mid_rst_exccode got %0d want 0", bus.ExcCode); end
    @(negedge clk); rst_n = 1'b1;
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_syscall();
    test_priority();
    test_interrupt();
    test_swint();
    test_masked();
    test_unimpl();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
Coprocessor-0 exception source for the single-cycle MIPS core: produces HasExp and EPC, and consumes ERET, which the PC next-address logic uses for redirection.
- Holds Status (12), Cause (13) and EPC (14); serves MTC0/MFC0.
- Synchronises external interrupt lines.
- Prioritises interrupt, undefined-instruction, overflow and syscall.
- Captures EPC and sets/clears EXL on exception entry and ERET.

Parameters:
SYNC_STAGES, 2, interrupt synchroniser depth (legal >= 2)
HW_INT_NUM, 6, number of hardware interrupt lines (maps to Cause.IP[2+HW_INT_NUM-1:2]; max 6)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
PresentPC  in  32  PC of instruction executing this cycle
IsCOP0  in  1  instruction is COP0 class
IsMtc0  in  1  MTC0 this cycle (valid with IsCOP0)
IsEret  in  1  ERET this cycle (acts only with IsCOP0)
IsSyscall  in  1  SYSCALL this cycle
IsUndef  in  1  reserved/undefined opcode this cycle
Overflow  in  1  ALU signed overflow from ADD/ADDI/SUB this cycle
Rd  in  5  CP0 register number for MTC0/MFC0
WriteData  in  32  GPR rt value for MTC0
HwInt  in  HW_INT_NUM  asynchronous level-sensitive interrupt requests
HasExp  out  1  exception taken this cycle (combinational)
EPC  out  32  EPC register
ReadData  out  32  MFC0 data, combinational mux on Rd
ExcCode  out  5  Cause.ExcCode register

Behaviour:
- Reset (async, rst_n=0):
  - Status=0 (IE=0, EXL=0, IM=0); Cause=0; EPC=0; synchroniser flops=0.
  - Outputs: HasExp=0, EPC=0, ExcCode=0. ReadData follows the mux, so Rd=12 reads 0.
- Register fields:
  - Status: [0] IE, [1] EXL, [15:8] IM; other bits read 0.
  - Cause: [6:2] ExcCode, [15:8] IP, [31] BD (always 0); other bits read 0.
  - EPC: [31:2] stored, [1:0] read 0.
- Interrupt path:
  - HwInt[i] passes through a SYNC_STAGES flop chain; the last stage drives Cause.IP[2+i] every cycle (level, not latched).
  - Latency: HwInt sampled high at edge N -> IP visible after edge N+SYNC_STAGES-1 -> HasExp in that cycle.
- Pending interrupt: IntReq = IE & ~EXL & |(IP & IM).
- HasExp = IntReq | ((IsUndef | Overflow | IsSyscall) & ~EXL).
- Priority (ExcCode): interrupt 0 > undefined 10 > overflow 12 > syscall 8.
- On a rising edge with HasExp=1:
  - EPC <= {PresentPC[31:2], 2'b00}.
  - EXL <= 1.
  - ExcCode <= winning code.
  - Any MTC0 or ERET in the same cycle is suppressed.
  - The core gates GPR/memory writes with HasExp and redirects to 0x00000800.
- Synchronous exception while EXL=1: ignored (HasExp=0, no state change). The handler must not fault.
- ERET (IsCOP0 & IsEret, HasExp=0):
  - EXL <= 0 at edge.
  - EPC unchanged; the PC block selects EPC this cycle.
- MTC0 (IsCOP0 & IsMtc0, HasExp=0):
  - Rd=12 writes IE, EXL, IM.
  - Rd=13 writes IP[1:0] only (software interrupts).
  - Rd=14 writes EPC[31:2].
  - Other Rd values are ignored.
  - The write is visible to MFC0 and IntReq from the next cycle.
- MFC0: ReadData = selected register; unimplemented Rd reads 0.
- Software interrupts IP[1:0] are subject to the same IntReq masking as hardware interrupts.
- Reset mid-handler: all state clears immediately; EXL=0 and interrupts are disabled until software sets IE.

Optional Feature:
CP0_TIMER_EN
- Defined:
  - Count (Rd 9) increments by 1 every cycle, wraps at 2^32; an MTC0 write to Count takes precedence over the increment.
  - Compare (Rd 11) is readable and writable.
  - When Count==Compare and Compare!=0, a sticky TimerPending flop sets at that edge.
  - IP[7] = synced HwInt[5] | TimerPending.
  - An MTC0 write to Compare clears TimerPending.
  - Reset: Count=0, Compare=0, TimerPending=0.
- Undefined: Rd 9 and 11 read 0, writes are ignored, IP[7] = synced HwInt[5] only.

Test Plan:
- Reset release, then MFC0 Rd=12,13,14 -> ReadData=0 each; HasExp=0.
- IsSyscall=1, PresentPC=0x00003010, EXL=0 -> HasExp=1 that cycle; after edge EPC=0x00003010, ExcCode=8, Status.EXL=1. A second IsSyscall -> HasExp=0.
- Same-cycle IsUndef and Overflow and IsSyscall -> ExcCode=10. The same cycle with MTC0 Rd=14 data 0x1234 -> EPC=PresentPC, not 0x1234.
- MTC0 Status=0x00000401 (IE=1, IM2); HwInt[0] rises before edge N -> HasExp=1 in cycle N+1, ExcCode=0. ERET -> EXL=0; HwInt still high re-enters next cycle.
- MTC0 Status with IM=0 and HwInt=all-ones -> HasExp never asserts; Cause.IP[7:2]=0x3F after 2 cycles.
- [CP0_TIMER_EN] Compare=5, Status=0x00008001 -> TimerPending sets when Count reaches 5, HasExp next cycle. MTC0 Compare clears it.
